// File: rtl/fdiv_pkg.sv
// Shared constants and types for the floating-point divide scheduler.
// Holds the state encoding, the timeout NaN and the divide-by-zero result.
package fdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fdiv_state_t;

  localparam logic [31:0] FDIV_QNAN = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG   = 31'h7F80_0000;

  // Divisor magnitude of zero (either sign) skips the divider core.
  function automatic logic is_zero_div(input logic [30:0] b_mag);
    return (b_mag == 31'd0);
  endfunction

  function automatic logic [31:0] div0_result(input logic a_sign, input logic b_sign);
    return {a_sign ^ b_sign, INF_MAG};
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: the pointer names the preferred requester
// when both are valid; a lone valid requester always wins.
module rr_pick2 (
  input  logic       v0,
  input  logic       v1,
  input  logic       ptr,
  output logic [1:0] grant
);

  // grant decode from the valid pair and the preference pointer
  always_comb begin
    grant = 2'b00;
    case ({v1, v0})
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/fdiv_scheduler.sv
// Shares one Goldschmidt divider core between two requesters, short-cuts
// divide-by-zero, and recovers from a hung core with a timeout and core reset.
module fdiv_scheduler
  import fdiv_pkg::*;
#(
  parameter int          TIMEOUT = 64,
  parameter logic [31:0] QNAN    = FDIV_QNAN
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_q,
  output logic [31:0] rsp_r,
  output logic        rsp_err,
  input  logic        rsp_ready,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  output logic        div_rst,
  input  logic        div_ready,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r
);

  localparam int CW = $clog2(TIMEOUT + 1);

  fdiv_state_t   state_r;
  logic          ptr_r;
  logic [CW-1:0] cnt_r;
  logic [31:0]   a_r;
  logic [31:0]   b_r;
  logic          id_r;
  logic          start_r;
  logic          drst_r;
  logic          rsp_valid_r;
  logic [31:0]   rsp_q_r;
  logic [31:0]   rsp_r_r;
  logic          rsp_err_r;

  logic [1:0]    grant_s;
  logic          idle_s;
  logic          acc0_s;
  logic          acc1_s;
  logic          acc_s;
  logic [31:0]   sel_a_s;
  logic [31:0]   sel_b_s;

  rr_pick2 u_pick (
    .v0    (req0_valid),
    .v1    (req1_valid),
    .ptr   (ptr_r),
    .grant (grant_s)
  );

  // Ready must answer the same-cycle valid, so it is decoded, and masked by clr.
  assign idle_s     = (state_r == ST_IDLE) & ~clr;
  assign req0_ready = idle_s & grant_s[0];
  assign req1_ready = idle_s & grant_s[1];
  assign acc0_s     = req0_valid & req0_ready;
  assign acc1_s     = req1_valid & req1_ready;
  assign acc_s      = acc0_s | acc1_s;

  // operand mux for the accepted requester
  always_comb begin
    sel_a_s = req0_a;
    sel_b_s = req0_b;
    if (acc1_s) begin
      sel_a_s = req1_a;
      sel_b_s = req1_b;
    end else begin
      sel_a_s = req0_a;
      sel_b_s = req0_b;
    end
  end

  // scheduler state machine with registered response and divider controls
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r     <= ST_IDLE;
      ptr_r       <= 1'b0;
      cnt_r       <= '0;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      id_r        <= 1'b0;
      start_r     <= 1'b0;
      drst_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_q_r     <= 32'd0;
      rsp_r_r     <= 32'd0;
      rsp_err_r   <= 1'b0;
    end else begin
      start_r <= 1'b0;
      drst_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (acc_s) begin
            a_r   <= sel_a_s;
            b_r   <= sel_b_s;
            id_r  <= acc1_s;
            ptr_r <= ~acc1_s;
            if (is_zero_div(sel_b_s[30:0])) begin
              state_r     <= ST_RESP;
              rsp_valid_r <= 1'b1;
              rsp_q_r     <= div0_result(sel_a_s[31], sel_b_s[31]);
              rsp_r_r     <= 32'd0;
              rsp_err_r   <= 1'b0;
            end else begin
              state_r <= ST_ISSUE;
              start_r <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          state_r <= ST_WAIT;
          cnt_r   <= '0;
        end
        ST_WAIT: begin
          // The core may still show a stale ready from a previous job on cycle one.
          if (div_ready && (cnt_r != '0)) begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_q_r     <= div_q;
            rsp_r_r     <= div_r;
            rsp_err_r   <= 1'b0;
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            state_r     <= ST_RESP;
            rsp_valid_r <= 1'b1;
            rsp_q_r     <= QNAN;
            rsp_r_r     <= 32'd0;
            rsp_err_r   <= 1'b1;
            drst_r      <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign div_a     = a_r;
  assign div_b     = b_r;
  assign div_start = start_r;
  assign div_rst   = clr | drst_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = id_r;
  assign rsp_q     = rsp_q_r;
  assign rsp_r     = rsp_r_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_fdiv_scheduler.sv
// Directed bench for fdiv_scheduler with a small behavioural divider core model.
`timescale 1ns/1ps
module tb_fdiv_scheduler;

  logic        clk = 1'b0;
  logic        clr;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_err, rsp_ready;
  logic [31:0] rsp_q, rsp_r;
  logic [31:0] div_a, div_b, div_q, div_r;
  logic        div_start, div_rst, div_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fdiv_scheduler #(.TIMEOUT(8)) dut (
    .clk(clk), .clr(clr),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r),
    .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .div_a(div_a), .div_b(div_b), .div_start(div_start), .div_rst(div_rst),
    .div_ready(div_ready), .div_q(div_q), .div_r(div_r)
  );

  // Divider model: ready on the dly-th cycle after the start cycle; dly=0 never.
  int          dly = 0;
  int          mcnt = 0;
  logic        busy = 1'b0;
  logic [31:0] mq = 32'd0;
  logic [31:0] mr = 32'd0;

  always @(posedge clk) begin
    if (div_rst) begin
      busy <= 1'b0;
      mcnt <= 0;
    end else if (div_start) begin
      busy <= 1'b1;
      mcnt <= 1;
    end else if (busy) begin
      mcnt <= mcnt + 1;
    end
  end

  assign div_ready = busy && (dly != 0) && (mcnt == dly);
  assign div_q     = mq;
  assign div_r     = mr;

  int starts = 0;
  int rst_cycles = 0;
  always @(posedge clk) begin
    if (div_start) starts <= starts + 1;
    if (div_rst && !clr) rst_cycles <= rst_cycles + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the first negedge after acceptance.
  task automatic accept(input int id, input logic [31:0] a, input logic [31:0] b);
    if (id == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b;
    end
    #1;
    check_eq("grant", {30'd0, req1_ready, req0_ready}, (id == 0) ? 32'd1 : 32'd2);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // n=1 means rsp_valid is visible one cycle after the acceptance edge.
  task automatic wait_rsp(output int n);
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic finish_rsp();
    check_eq("no_ready_in_resp", {31'd0, req0_ready | req1_ready}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("rsp_done", {31'd0, rsp_valid}, 32'd0);
  endtask

  int n;
  int s0;
  int r0;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h4000_0000; req0_b = 32'h3F00_0000;
    req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_q", rsp_q, 32'd0);
    check_eq("rst_div_a", div_a, 32'd0);
    check_eq("rst_div_start", {31'd0, div_start}, 32'd0);
    check_eq("rst_div_rst", {31'd0, div_rst}, 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    clr = 1'b0;
    @(negedge clk);

    // 2.0 / 0.5 through the divider, ready in the 5th cycle after start
    dly = 5; mq = 32'h4080_0000; mr = 32'd0; s0 = starts; r0 = rst_cycles;
    accept(0, 32'h4000_0000, 32'h3F00_0000);
    check_eq("t1_start_issue", {31'd0, div_start}, 32'd1);
    wait_rsp(n);
    check_eq("t1_latency", n, 32'd7);
    check_eq("t1_id", {31'd0, rsp_id}, 32'd0);
    check_eq("t1_q", rsp_q, 32'h4080_0000);
    check_eq("t1_err", {31'd0, rsp_err}, 32'd0);
    check_eq("t1_div_a", div_a, 32'h4000_0000);
    check_eq("t1_div_b", div_b, 32'h3F00_0000);
    check_eq("t1_starts", starts - s0, 32'd1);
    check_eq("t1_no_drst", rst_cycles - r0, 32'd0);
    finish_rsp();

    // -3.0 / -0.0 bypasses the core
    mr = 32'h1234_5678; s0 = starts;
    accept(1, 32'hC040_0000, 32'h8000_0000);
    wait_rsp(n);
    check_eq("t2_latency", n, 32'd1);
    check_eq("t2_id", {31'd0, rsp_id}, 32'd1);
    check_eq("t2_q", rsp_q, 32'h7F80_0000);
    check_eq("t2_r", rsp_r, 32'd0);
    check_eq("t2_err", {31'd0, rsp_err}, 32'd0);
    check_eq("t2_no_start", starts - s0, 32'd0);
    finish_rsp();

    // both requesters always valid: grants alternate starting at 0
    dly = 2; mr = 32'd0;
    req0_a = 32'h4100_0000; req0_b = 32'h4000_0000;
    req1_a = 32'h4140_0000; req1_b = 32'h4040_0000;
    for (int i = 0; i < 4; i++) begin
      mq = 32'h3F80_0000 | i;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check_eq("rr_grant", {30'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge clk);
      @(negedge clk);
      wait_rsp(n);
      check_eq("rr_latency", n, 32'd4);
      check_eq("rr_id", {31'd0, rsp_id}, i % 2);
      check_eq("rr_q", rsp_q, 32'h3F80_0000 | i);
      finish_rsp();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // hung divider: timeout after 8 WAIT cycles, then a long response stall
    dly = 0; mr = 32'hDEAD_BEEF; r0 = rst_cycles;
    accept(0, 32'h3F80_0000, 32'h4000_0000);
    wait_rsp(n);
    check_eq("to_latency", n, 32'd10);
    check_eq("to_drst_now", {31'd0, div_rst}, 32'd1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check_eq("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("stall_q", rsp_q, 32'h7FC0_0000);
      check_eq("stall_r", rsp_r, 32'd0);
      check_eq("stall_err", {30'd0, rsp_id, rsp_err}, 32'd1);
      check_eq("stall_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_eq("to_drst_pulse", rst_cycles - r0, 32'd1);
    finish_rsp();

    // ready only in the first WAIT cycle must be ignored -> timeout
    dly = 1; r0 = rst_cycles;
    accept(1, 32'h4000_0000, 32'h4000_0000);
    wait_rsp(n);
    check_eq("w1_latency", n, 32'd10);
    check_eq("w1_err", {31'd0, rsp_err}, 32'd1);
    finish_rsp();
    check_eq("w1_drst_pulse", rst_cycles - r0, 32'd1);

    // ready on the timeout cycle wins
    dly = 8; mq = 32'h4100_0000; mr = 32'h0000_0001; r0 = rst_cycles;
    accept(0, 32'h4100_0000, 32'h3F80_0000);
    wait_rsp(n);
    check_eq("tie_latency", n, 32'd10);
    check_eq("tie_q", rsp_q, 32'h4100_0000);
    check_eq("tie_r", rsp_r, 32'h0000_0001);
    check_eq("tie_err", {31'd0, rsp_err}, 32'd0);
    finish_rsp();
    check_eq("tie_no_drst", rst_cycles - r0, 32'd0);

    // clr mid-WAIT drops the request and resets the core
    dly = 0;
    accept(1, 32'h4000_0000, 32'h4040_0000);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    #1;
    check_eq("clr_div_rst", {31'd0, div_rst}, 32'd1);
    check_eq("clr_div_b", div_b, 32'd0);
    check_eq("clr_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    @(negedge clk);
    check_eq("clr_div_rst_held", {31'd0, div_rst}, 32'd1);
    clr = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("clr_dropped", {31'd0, rsp_valid}, 32'd0);
    dly = 3; mq = 32'h4040_0000; mr = 32'd0;
    req0_a = 32'h40C0_0000; req0_b = 32'h4000_0000;
    req1_a = 32'h4000_0000; req1_b = 32'h4000_0000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_eq("clr_ptr_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(n);
    check_eq("post_latency", n, 32'd5);
    check_eq("post_id", {31'd0, rsp_id}, 32'd0);
    check_eq("post_q", rsp_q, 32'h4040_0000);
    check_eq("post_err", {31'd0, rsp_err}, 32'd0);
    finish_rsp();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fdiv_scheduler.md
FDIV_SCHEDULER -- requirements
Module: fdiv_scheduler

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: WAIT-cycle limit before the divider is declared hung.
REQ-002 SHALL have parameter QNAN, default 32'h7FC0_0000: quotient returned on timeout.
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port clr  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req0_valid/req1_valid  in  1  requester n has an operand pair.
REQ-006 SHALL have ports req0_a/req1_a  in  32  IEEE-754 single dividend.
REQ-007 SHALL have ports req0_b/req1_b  in  32  IEEE-754 single divisor.
REQ-008 SHALL have ports req0_ready/req1_ready  out  1  request n accepted this cycle.
REQ-009 SHALL have ports rsp_valid out 1, rsp_id out 1, rsp_q out 32, rsp_r out 32, rsp_err out 1; and rsp_ready in 1.
REQ-010 SHALL have ports div_a/div_b out 32, div_start out 1, div_rst out 1 (active-high), div_ready in 1, div_q/div_r in 32, connecting to the shared Goldschmidt divider core.

Function
REQ-011 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-012 SHALL assert reqN_ready only in IDLE, for at most one N per cycle; acceptance is reqN_valid & reqN_ready.
REQ-013 SHALL arbitrate round-robin: 1-bit pointer names the preferred requester; if only one is valid, it wins; the pointer moves to the other requester after every acceptance.
REQ-014 SHALL, on acceptance, latch a, b and id into internal registers.
REQ-015 SHALL treat divisor zero (b[30:0]==0) as a bypass: IDLE->RESP directly; rsp_q = {a[31]^b[31], 31'h7F80_0000}, rsp_r = 0, rsp_err = 0; the divider is not started.
REQ-016 SHALL, for a nonzero divisor, go IDLE->ISSUE and assert div_start for exactly one cycle in ISSUE, then go to WAIT.
REQ-017 SHALL hold div_a/div_b at the latched operands from ISSUE through the WAIT exit.
REQ-018 SHALL ignore div_ready during the first WAIT cycle; from the second WAIT cycle on, div_ready=1 captures div_q/div_r into rsp_q/rsp_r with rsp_err=0 and moves to RESP.
REQ-019 SHALL count WAIT cycles; if count reaches TIMEOUT without a capture, it moves to RESP with rsp_q=QNAN, rsp_r=0, rsp_err=1, and pulses div_rst for exactly one cycle.
REQ-020 SHALL, if div_ready and the timeout coincide on the same cycle, give div_ready priority: normal capture, no div_rst.
REQ-021 SHALL, in RESP, hold rsp_valid=1 and rsp_q, rsp_r, rsp_id, rsp_err stable until rsp_ready=1, then go to IDLE.
REQ-022 SHALL NOT accept a new request in the cycle rsp_ready completes a response; the earliest acceptance is the next IDLE cycle.
REQ-023 SHALL meet these latencies from the acceptance edge: bypass rsp_valid after 1 cycle; normal rsp_valid 1 cycle after the capturing div_ready edge.

Reset
REQ-024 SHALL, on clr=1, immediately force state=IDLE, pointer=0, WAIT count=0, and drive all outputs to 0: reqN_ready, rsp_*, div_start, div_a, div_b.
REQ-025 SHALL assert div_rst=1 while clr=1, so that a reset mid-WAIT also clears the divider core.
REQ-026 SHALL drop any in-flight request on reset; it is never answered.

Structure
REQ-027 SHALL place the state encoding, QNAN and the +inf magnitude constant 31'h7F80_0000 in a shared package fdiv_pkg.
REQ-028 SHALL factor the arbiter into one sub-module, rr_pick2 (inputs: two valids and the pointer; output: grant vector); the divider core is instantiated outside this block.

Verification
REQ-029 SHALL cover: req0 a=0x40000000, b=0x3F000000, divider model returns ready after 5 cycles with q=0x40800000 -> rsp_id=0, rsp_q=0x40800000, rsp_err=0, and div_start high exactly one cycle.
REQ-030 SHALL cover: both valid, back-to-back, for 4 transactions -> grants alternate 0,1,0,1 and rsp_id follows the same order.
REQ-031 SHALL cover: req1 a=0xC0400000, b=0x80000000 -> rsp_q=0x7F800000, rsp_err=0 one cycle after acceptance, with no div_start.
REQ-032 SHALL cover: divider never ready, TIMEOUT=8 -> rsp_err=1 and rsp_q=0x7FC00000 after 8 WAIT cycles, with a one-cycle div_rst pulse.
REQ-033 SHALL cover: rsp_ready held 0 for 10 cycles -> rsp_* stable throughout and reqN_ready=0 throughout.
REQ-034 SHALL cover: clr asserted mid-WAIT -> all outputs 0 and div_rst=1 while clr=1; after release, a new request completes normally.
